apb_rr_fabric: RTL and testbench

Parametrised N-master / M-slave APB interconnect. It replaces the fixed 3x3 fabric with a generic master and slave count, a true rotating-pointer round-robin arbiter and a registered command/response path. It adds decode-error handling and per-master ready/error return. It sits between the APB master bridges and the peripheral slaves.

---
 rtl/apb_fabric_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 59 +++++
 rtl/apb_rr_fabric.sv | 198 +++++++++++++++++++
 tb/tb_apb_rr_fabric.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_fabric_pkg.sv
// Shared types and helpers for the N-master / M-slave APB round-robin fabric.
// The command and response records depend on the bus widths, so they are
// typedef'd inside the fabric from its parameters. This package holds the
// width-independent pieces: the transfer FSM state and the wrap helper.
package apb_fabric_pkg;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Wrap an index that may run at most one full lap past count back into
  // [0, count). The explicit compare keeps this correct when count is not
  // a power of two.
  function automatic int rr_wrap(input int idx, input int count);
    return (idx >= count) ? (idx - count) : idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-pointer round-robin arbiter. The search starts at the pointer and
// wraps modulo MASTER_COUNT. The first requester found wins. On i_advance the
// pointer moves to one past the current winner, so that master becomes the
// lowest priority for the next arbitration.
module rr_arbiter
  import apb_fabric_pkg::*;
#(
  parameter  int MASTER_COUNT = 3,
  localparam int PTR_W        = $clog2(MASTER_COUNT)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [MASTER_COUNT-1:0] i_req,
  input  logic                    i_advance,
  output logic [MASTER_COUNT-1:0] o_gnt_onehot,
  output logic [PTR_W-1:0]        o_gnt_idx
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(MASTER_COUNT - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Rotate by the pointer, priority-encode, and map the winner back to its real index.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value held over from the previous evaluation and no latch is inferred.
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    found        = 1'b0;
    cand         = '0;
    for (int i = 0; i < MASTER_COUNT; i++) begin
      cand = PTR_W'(rr_wrap(int'(ptr_q) + i, MASTER_COUNT));
      if (!found && i_req[cand]) begin
        found             = 1'b1;
        o_gnt_idx         = cand;
        o_gnt_onehot[cand] = 1'b1;
      end
    end
  end

  // The next pointer is one past the winner, with an explicit wrap at the last master.
  always_comb begin
    ptr_d = ptr_q;
    if (i_advance) begin
      ptr_d = (o_gnt_idx == LAST_IDX) ? '0 : (o_gnt_idx + PTR_W'(1));
    end
  end

  // Pointer register. Reset gives master 0 the highest priority.
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values, regardless of statement or block order.
    if (!i_rst) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/apb_rr_fabric.sv
// Parametrised N-master / M-slave APB interconnect with round-robin arbitration.
// A request is a nonzero psel slice. The winning master's command is frozen in
// cmd_q for the whole transfer. A command that is not one-hot skips the slave
// side and returns an error. Optional build macro APB_TIMEOUT_EN adds an
// ACCESS-phase watchdog that aborts with an error after TIMEOUT_CYCLES cycles.
module apb_rr_fabric
  import apb_fabric_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MASTER_COUNT   = 3,
  parameter int SLAVE_COUNT    = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [MASTER_COUNT*ADDR_WIDTH-1:0]  i_paddr,
  input  logic [MASTER_COUNT-1:0]             i_pwrite,
  input  logic [MASTER_COUNT*SLAVE_COUNT-1:0] i_psel,
  input  logic [MASTER_COUNT-1:0]             i_penable,
  input  logic [MASTER_COUNT*DATA_WIDTH-1:0]  i_pwdata,
  output logic [DATA_WIDTH-1:0]               o_prdata_m,
  output logic [MASTER_COUNT-1:0]             o_pready_m,
  output logic [MASTER_COUNT-1:0]             o_pslverr_m,
  output logic [ADDR_WIDTH-1:0]               o_paddr,
  output logic                                o_pwrite,
  output logic [SLAVE_COUNT-1:0]              o_psel,
  output logic                                o_penable,
  output logic [DATA_WIDTH-1:0]               o_pwdata,
  input  logic [SLAVE_COUNT*DATA_WIDTH-1:0]   i_prdata,
  input  logic [SLAVE_COUNT-1:0]              i_pready,
  input  logic [SLAVE_COUNT-1:0]              i_pslverr,
  output logic [MASTER_COUNT-1:0]             o_gnt,
  output logic                                o_busy
);

  localparam int PTR_W = $clog2(MASTER_COUNT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   write;
    logic [SLAVE_COUNT-1:0] sel;
    logic [DATA_WIDTH-1:0]  wdata;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_t;

  state_e                  state_q;
  cmd_t                    cmd_q;
  rsp_t                    rsp_q;
  logic [MASTER_COUNT-1:0] gnt_q;
  logic [SLAVE_COUNT-1:0]  psel_q;
  logic                    penable_q;
  logic [MASTER_COUNT-1:0] pready_m_q;

  logic [MASTER_COUNT-1:0] req;
  logic [MASTER_COUNT-1:0] arb_req;
  logic [MASTER_COUNT-1:0] arb_gnt;
  logic [PTR_W-1:0]        arb_idx;
  cmd_t                    win_cmd;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    tmo_hit;

  // Master-side enable carries no information the fabric needs.
  logic penable_unused;
  assign penable_unused = &i_penable;

  // A master requests whenever any bit of its psel slice is set.
  always_comb begin
    req = '0;
    for (int k = 0; k < MASTER_COUNT; k++) begin
      req[k] = |i_psel[k*SLAVE_COUNT +: SLAVE_COUNT];
    end
  end

  // Outside IDLE the arbiter sees only the latched winner, so its index (and
  // the pointer advance in DONE) cannot be disturbed by late requesters.
  assign arb_req = (state_q == ST_IDLE) ? req : gnt_q;

  rr_arbiter #(
    .MASTER_COUNT (MASTER_COUNT)
  ) u_arb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req        (arb_req),
    .i_advance    (state_q == ST_DONE),
    .o_gnt_onehot (arb_gnt),
    .o_gnt_idx    (arb_idx)
  );

  // Select the winning master's command fields.
  always_comb begin
    win_cmd.addr  = i_paddr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
    win_cmd.write = i_pwrite[arb_idx];
    win_cmd.sel   = i_psel[arb_idx*SLAVE_COUNT +: SLAVE_COUNT];
    win_cmd.wdata = i_pwdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // Return path from the selected slave only. Other slaves are masked off.
  assign sel_ready = |(i_pready & cmd_q.sel);
  assign sel_err   = |(i_pslverr & cmd_q.sel);

  // OR-mux of read data, gated by the latched one-hot select.
  always_comb begin
    sel_rdata = '0;
    for (int s = 0; s < SLAVE_COUNT; s++) begin
      if (cmd_q.sel[s]) sel_rdata = sel_rdata | i_prdata[s*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  // The watchdog clears in SETUP (just before ACCESS) and counts every ACCESS cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                      tmo_cnt_q <= '0;
    else if (state_q == ST_SETUP)    tmo_cnt_q <= '0;
    else if (state_q == ST_ACCESS)   tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end

  // The last permitted ACCESS cycle is the one in which the count reads TIMEOUT_CYCLES-1.
  assign tmo_hit = (state_q == ST_ACCESS) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Transfer sequencer: latch in IDLE, strobe the slave, return the response in DONE.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      rsp_q      <= '0;
      gnt_q      <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pready_m_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            cmd_q <= win_cmd;
            gnt_q <= arb_gnt;
            if ($onehot(win_cmd.sel)) begin
              psel_q  <= win_cmd.sel;
              state_q <= ST_SETUP;
            end else begin
              // Decode error: no slave strobe, answer the master straight away.
              rsp_q.rdata <= '0;
              rsp_q.err   <= 1'b1;
              pready_m_q  <= arb_gnt;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready || tmo_hit) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_q.err   <= sel_ready ? sel_err : 1'b1;
            rsp_q.rdata <= (sel_ready && !sel_err && !cmd_q.write) ? sel_rdata : '0;
            pready_m_q  <= gnt_q;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          pready_m_q <= '0;
          rsp_q      <= '0;
          gnt_q      <= '0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_prdata_m  = rsp_q.rdata;
  assign o_pready_m  = pready_m_q;
  assign o_pslverr_m = pready_m_q & {MASTER_COUNT{rsp_q.err}};
  assign o_paddr     = cmd_q.addr;
  assign o_pwrite    = cmd_q.write;
  assign o_pwdata    = cmd_q.wdata;
  assign o_psel      = psel_q;
  assign o_penable   = penable_q;
  assign o_gnt       = gnt_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_rr_fabric.sv
// Self-checking bench for apb_rr_fabric (3 masters, 3 slaves, 32-bit buses).
// Single-master transfers come from a table of hand-computed records. Round
// robin, reset mid-transfer and (with APB_TIMEOUT_EN) the watchdog are
// hand-written sequences.
module tb_apb_rr_fabric;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int M  = 3;
  localparam int S  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [M*AW-1:0]   paddr;
  logic [M-1:0]      pwrite;
  logic [M*S-1:0]    psel;
  logic [M-1:0]      penable;
  logic [M*DW-1:0]   pwdata;
  logic [DW-1:0]     o_prdata_m;
  logic [M-1:0]      o_pready_m;
  logic [M-1:0]      o_pslverr_m;
  logic [AW-1:0]     o_paddr;
  logic              o_pwrite;
  logic [S-1:0]      o_psel;
  logic              o_penable;
  logic [DW-1:0]     o_pwdata;
  logic [S*DW-1:0]   prdata;
  logic [S-1:0]      pready;
  logic [S-1:0]      pslverr;
  logic [M-1:0]      o_gnt;
  logic              o_busy;

  // Slave side: either a zero-wait auto responder or table-driven ready/error.
  logic              auto_mode;
  logic [S-1:0]      auto_ready = '0;
  logic [S-1:0]      t_ready;
  logic [S-1:0]      t_err;
  assign pready  = auto_mode ? auto_ready : t_ready;
  assign pslverr = auto_mode ? '0 : t_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          m;
    logic [2:0]  sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        serr;
    logic        dec_err;
    logic [2:0]  exp_pready;
    logic [2:0]  exp_pslverr;
    logic [31:0] exp_prdata;
    int          exp_lat;
  } vec_t;

  vec_t       vecs [6];
  logic [2:0] rr_exp [4];

  apb_rr_fabric #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .MASTER_COUNT   (M),
    .SLAVE_COUNT    (S),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_paddr     (paddr),
    .i_pwrite    (pwrite),
    .i_psel      (psel),
    .i_penable   (penable),
    .i_pwdata    (pwdata),
    .o_prdata_m  (o_prdata_m),
    .o_pready_m  (o_pready_m),
    .o_pslverr_m (o_pslverr_m),
    .o_paddr     (o_paddr),
    .o_pwrite    (o_pwrite),
    .o_psel      (o_psel),
    .o_penable   (o_penable),
    .o_pwdata    (o_pwdata),
    .i_prdata    (prdata),
    .i_pready    (pready),
    .i_pslverr   (pslverr),
    .o_gnt       (o_gnt),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Zero-wait responder: ready during the ACCESS cycle of whichever slave is strobed.
  always @(negedge clk) auto_ready = o_psel & {S{o_penable}};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_master(input int m, input logic [S-1:0] sel, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata);
    psel[m*S +: S]    = sel;
    pwrite[m]         = wr;
    paddr[m*AW +: AW] = addr;
    pwdata[m*DW +: DW] = wdata;
  endtask

  // Count edges until an o_pready_m pulse is seen, bounded at 40.
  task automatic wait_pready(output int n);
    n = 0;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
    end while (o_pready_m == '0 && n < 40);
  endtask

  // One table transfer. Cycle c is the c-th edge after the request is driven.
  // Unselected slaves hold ready and error high throughout, so any leak of
  // their handshake into the fabric shows up as early completion or a wrong error.
  task automatic run_vec(input vec_t v);
    int done_c;
    done_c = -1;
    for (int s = 0; s < S; s++)
      prdata[s*DW +: DW] = v.sel[s] ? v.rdata : (32'hBAD0_0000 | 32'(s));
    t_err   = ~v.sel | (v.serr ? v.sel : 3'b000);
    t_ready = ~v.sel;
    drive_master(v.m, v.sel, v.wr, v.addr, v.wdata);
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) begin
        check("gnt_setup", 64'(o_gnt), 64'(v.exp_pready));
        check("psel_setup", 64'(o_psel), v.dec_err ? 64'h0 : 64'(v.sel));
        check("penable_setup", 64'(o_penable), 64'h0);
        // Master inputs change mid-transfer. The latched command must not follow them.
        drive_master(v.m, v.sel, ~v.wr, ~v.addr, ~v.wdata);
      end
      if (c == 2 && !v.dec_err) begin
        check("penable_access", 64'(o_penable), 64'h1);
        check("cmd_addr", 64'(o_paddr), 64'(v.addr));
        check("cmd_wdata", 64'(o_pwdata), 64'(v.wdata));
        check("cmd_write", 64'(o_pwrite), 64'(v.wr));
      end
      if (o_pready_m != '0) begin
        done_c = c;
        check("pready_m", 64'(o_pready_m), 64'(v.exp_pready));
        check("pslverr_m", 64'(o_pslverr_m), 64'(v.exp_pslverr));
        check("prdata_m", 64'(o_prdata_m), 64'(v.exp_prdata));
      end
      t_ready = ~v.sel | ((c == 2 + v.waits) ? v.sel : 3'b000);
    end
    check("latency", 64'(done_c), 64'(v.exp_lat));
    psel[v.m*S +: S] = '0;
    t_ready = '0;
    t_err   = '0;
    @(posedge clk); @(negedge clk);
    check("idle_after", 64'({o_busy, o_gnt, o_pready_m}), 64'h0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    paddr     = '0;
    pwrite    = '0;
    psel      = '0;
    penable   = '1;
    pwdata    = '0;
    prdata    = '0;
    auto_mode = 1'b0;
    t_ready   = '0;
    t_err     = '0;

    //            m  sel     wr    addr          wdata         W  rdata         serr  dec   pready  pslverr prdata        lat
    vecs[0] = '{1, 3'b100, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 0, 32'h5555_5555, 1'b0, 1'b0, 3'b010, 3'b000, 32'h0000_0000, 3};
    vecs[1] = '{2, 3'b001, 1'b0, 32'h0000_0010, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 1'b0, 3'b100, 3'b000, 32'h1234_5678, 6};
    vecs[2] = '{0, 3'b011, 1'b0, 32'h0000_0030, 32'h0000_0000, 0, 32'h9999_9999, 1'b0, 1'b1, 3'b001, 3'b001, 32'h0000_0000, 1};
    vecs[3] = '{0, 3'b010, 1'b0, 32'h0000_0044, 32'h0000_0000, 1, 32'hAAAA_5555, 1'b1, 1'b0, 3'b001, 3'b001, 32'h0000_0000, 4};
    vecs[4] = '{1, 3'b010, 1'b0, 32'h0000_0048, 32'h0000_0000, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 3'b010, 3'b000, 32'hCAFE_F00D, 3};
    vecs[5] = '{2, 3'b010, 1'b1, 32'h0000_004C, 32'h0BAD_F00D, 2, 32'h1111_2222, 1'b0, 1'b0, 3'b100, 3'b000, 32'h0000_0000, 5};
    rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr_data", 64'({o_paddr, o_pwdata}), 64'h0);
    check("rst_ctrl", 64'({o_prdata_m, o_pready_m, o_pslverr_m, o_pwrite, o_psel, o_penable, o_gnt, o_busy}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-master transfers.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Round robin: after vec 5 (master 2) the pointer is back at 0. All three
    // masters request at once. Master 0 keeps requesting, so its second turn
    // comes only after master 2. Zero-wait transfers are 4 cycles apart.
    auto_mode = 1'b1;
    for (int s = 0; s < S; s++) prdata[s*DW +: DW] = 32'h1000_0000 + 32'(s);
    drive_master(0, 3'b001, 1'b0, 32'h100, 32'h0);
    drive_master(1, 3'b010, 1'b0, 32'h104, 32'h0);
    drive_master(2, 3'b100, 1'b0, 32'h108, 32'h0);
    for (int g = 0; g < 4; g++) begin
      wait_pready(n);
      check("rr_order", 64'(o_pready_m), 64'(rr_exp[g]));
      check("rr_gnt", 64'(o_gnt), 64'(rr_exp[g]));
      check("rr_rdata", 64'(o_prdata_m), 64'(32'h1000_0000 + 32'(g % 3)));
      check("rr_gap", 64'(n), (g == 0) ? 64'd3 : 64'd4);
      if (o_pready_m[1]) psel[1*S +: S] = '0;
      if (o_pready_m[2]) psel[2*S +: S] = '0;
      if (g == 3) psel[0 +: S] = '0;
    end
    @(posedge clk); @(negedge clk);
    check("rr_idle", 64'({o_busy, o_gnt}), 64'h0);

    // Reset during ACCESS. The pointer is now 1 (master 0 was last served);
    // master 1 starts a transfer to a slave that never answers.
    auto_mode = 1'b0;
    t_ready   = '0;
    drive_master(1, 3'b001, 1'b1, 32'h200, 32'h5A5A_5A5A);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("rst_pre_access", 64'({o_busy, o_penable}), 64'h3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_addr_data", 64'({o_paddr, o_pwdata}), 64'h0);
    check("rst_mid_ctrl", 64'({o_prdata_m, o_pready_m, o_pslverr_m, o_pwrite, o_psel, o_penable, o_gnt, o_busy}), 64'h0);
    psel[1*S +: S] = '0;
    @(posedge clk); @(negedge clk);
    check("rst_no_pready", 64'(o_pready_m), 64'h0);
    // Masters 0 and 2 compete. A pointer back at 0 picks master 0.
    // A pointer left at 1 would pick master 2.
    drive_master(0, 3'b010, 1'b0, 32'h300, 32'h0);
    drive_master(2, 3'b100, 1'b0, 32'h304, 32'h0);
    auto_mode = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_ptr_gnt", 64'(o_gnt), 64'h1);
    wait_pready(n);
    check("rst_ptr_first", 64'(o_pready_m), 64'h1);
    psel[0 +: S] = '0;
    wait_pready(n);
    check("rst_ptr_second", 64'(o_pready_m), 64'h4);
    psel[2*S +: S] = '0;
    @(posedge clk); @(negedge clk);

`ifdef APB_TIMEOUT_EN
    // Watchdog: the pointer is 0 here. Master 1 reads slave 0, which never
    // answers. ACCESS occupies cycles 2..17 and the error pulse comes in cycle 18.
    auto_mode = 1'b0;
    t_ready   = '0;
    t_err     = '0;
    prdata[0 +: DW] = 32'h7777_7777;
    drive_master(1, 3'b001, 1'b0, 32'h400, 32'h0);
    wait_pready(n);
    check("tmo_latency", 64'(n), 64'd18);
    check("tmo_pready", 64'(o_pready_m), 64'h2);
    check("tmo_pslverr", 64'(o_pslverr_m), 64'h2);
    check("tmo_prdata", 64'(o_prdata_m), 64'h0);
    psel[1*S +: S] = '0;
    @(posedge clk); @(negedge clk);
    // The pointer advanced to 2, so master 2 beats master 1.
    auto_mode = 1'b1;
    drive_master(1, 3'b010, 1'b0, 32'h404, 32'h0);
    drive_master(2, 3'b010, 1'b0, 32'h408, 32'h0);
    @(posedge clk); @(negedge clk);
    check("tmo_ptr_gnt", 64'(o_gnt), 64'h4);
    for (int k = 0; k < 2; k++) begin
      wait_pready(n);
      if (o_pready_m[1]) psel[1*S +: S] = '0;
      if (o_pready_m[2]) psel[2*S +: S] = '0;
    end
    @(posedge clk); @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
